regfile_mp: RTL and testbench

Parametrised multi-port integer register file with write-through bypass and a per-register pending-write scoreboard. It replaces the single-write, dual-read, negative-edge register file in the core. All state updates on the rising edge of one clock. Same-cycle write-to-read forwarding gives the decode stage correct operands without a half-cycle write. The scoreboard gives the hazard unit a per-operand "value not yet written back" flag, so multi-cycle units can retire out of order.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/regfile_mp.sv | 110 +++++++++++
 tb/tb_regfile_mp.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and write-port record for the
// multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;

  // Upper bounds for the generic write-port record; instances narrow it.
  localparam int AW_MAX   = 16;
  localparam int XLEN_MAX = 128;

  function automatic int calc_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  typedef struct packed {
    logic                en;
    logic [AW_MAX-1:0]   addr;
    logic [XLEN_MAX-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file access bus: read ports, write ports, scoreboard alloc and
// the drain flag, with master (pipeline) and slave (register file) views.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = calc_aw(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_pend;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;
  logic                     busy_any;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_pend, busy_any
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_pend, busy_any
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by alloc, cleared by
// write-back, with a post-edge view per read port and a registered drain flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  output logic [NRD-1:0]         rd_pend,
  output logic                   busy_any
);

  logic [NREGS-1:0] pend_reg;
  logic [NREGS-1:0] pend_next;

  function automatic logic wr_hits(input logic [AW-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && wr_addr[i] == a) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // A new producer allocated in the same cycle as the old one retires keeps
  // the register pending.
  always_comb begin
    pend_next = pend_reg;
    for (int r = 0; r < NREGS; r++) begin
      if (alloc_en && alloc_addr == AW'(r)) begin
        pend_next[r] = 1'b1;
      end else if (wr_hits(AW'(r))) begin
        pend_next[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      pend_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_pend
      assign rd_pend[gi] = pend_reg[rd_addr[gi]] &
                           ~(wr_hits(rd_addr[gi]) &
                             ~(alloc_en && alloc_addr == rd_addr[gi]));
    end
  endgenerate

  assign busy_any = |pend_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port flop register file with same-cycle write-through bypass and a
// pending-write scoreboard for the hazard unit.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);

  localparam int AW = calc_aw(NREGS);

  logic [XLEN-1:0] regs_reg [NREGS];
  logic [XLEN-1:0] reg_wdata [NREGS];
  logic [NREGS-1:0] reg_we;

  wr_port_t        wp [NWR];
  logic [NWR-1:0]  w_en;
  logic [AW-1:0]   w_addr [NWR];
  logic [XLEN-1:0] w_data [NWR];
  logic [NWR-1:0]  wp_pad_unused;

  // Ports are carried as full-width records and narrowed to this instance.
  generate
    for (genvar gi = 0; gi < NWR; gi++) begin : g_wp
      assign wp[gi] = '{en:   bus.wr_en[gi],
                        addr: AW_MAX'(bus.wr_addr[gi]),
                        data: XLEN_MAX'(bus.wr_data[gi])};
      assign w_en[gi]          = wp[gi].en;
      assign w_addr[gi]        = wp[gi].addr[AW-1:0];
      assign w_data[gi]        = wp[gi].data[XLEN-1:0];
      assign wp_pad_unused[gi] = ^wp[gi];
    end
  endgenerate

  // Later ports override earlier ones, so the highest index wins.
  always_comb begin
    reg_we = '0;
    for (int r = 0; r < NREGS; r++) begin
      reg_wdata[r] = '0;
      for (int i = 0; i < NWR; i++) begin
        if (w_en[i] && w_addr[i] == AW'(r)) begin
          reg_we[r]    = 1'b1;
          reg_wdata[r] = w_data[i];
        end
      end
    end
    if (ZERO_REG != 0) begin
      reg_we[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_reg[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (reg_we[r]) begin
          regs_reg[r] <= reg_wdata[r];
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = regs_reg[a];
    for (int i = 0; i < NWR; i++) begin
      if (w_en[i] && w_addr[i] == a) begin
        v = w_data[i];
      end
    end
    if (ZERO_REG != 0 && a == '0) begin
      v = '0;
    end
    return v;
  endfunction

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      assign bus.rd_data[gi] = read_mux(bus.rd_addr[gi]);
    end
  endgenerate

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .rd_addr    (bus.rd_addr),
    .rd_pend    (bus.rd_pend),
    .busy_any   (bus.busy_any)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (two write ports): expectations
// are queued with their cycle tag and checked by an independent monitor.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;   // 0 rd_data, 1 rd_pend, 2 busy_any
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic expect_val(input string nm, input int kind, input int port,
                            input logic [31:0] e);
    exp_t x;
    x.cyc  = cyc;
    x.name = nm;
    x.kind = kind;
    x.port = port;
    x.exp  = e;
    sbq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.alloc_en = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.wr_en[p]   = 1'b1;
    bus.wr_addr[p] = 5'(a);
    bus.wr_data[p] = d;
  endtask

  task automatic alloc(input int a);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = 5'(a);
  endtask

  // Monitor: compares every expectation tagged for the current cycle.
  initial begin
    exp_t        x;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        x = sbq.pop_front();
        case (x.kind)
          0:       act = bus.rd_data[x.port];
          1:       act = {31'b0, bus.rd_pend[x.port]};
          default: act = {31'b0, bus.busy_any};
        endcase
        n_cmp++;
        if (x.cyc != cyc || act !== x.exp) begin
          n_bad++;
          $display("FAIL %s: cycle %0d got %h expected %h (tag %0d)",
                   x.name, cyc, act, x.exp, x.cyc);
        end else begin
          $display("ok   %s: cycle %0d value %h", x.name, cyc, act);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    n_cmp = 0;
    n_bad = 0;
    bus.rd_addr    = '0;
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;

    // Reset overrides a concurrent write and alloc.
    rst_n = 1'b0;
    wr(0, 5, 32'hDEADBEEF);
    alloc(5);
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd0;
    expect_val("rst_rd0", 0, 0, 32'h0);
    expect_val("rst_pend0", 1, 0, 32'h0);
    expect_val("rst_busy", 2, 0, 32'h0);
    expect_val("rst_rd1", 0, 1, 32'h0);
    tick();

    // Write x7 with bypass, then from the array.
    wr(0, 7, 32'h12345678);
    bus.rd_addr[0] = 5'd7;
    expect_val("byp_x7", 0, 0, 32'h12345678);
    tick();
    idle();
    expect_val("arr_x7", 0, 0, 32'h12345678);
    tick();

    // Zero register ignores writes, no bypass.
    wr(0, 0, 32'hFFFFFFFF);
    bus.rd_addr[0] = 5'd0;
    bus.rd_addr[1] = 5'd0;
    expect_val("zr_byp0", 0, 0, 32'h0);
    expect_val("zr_byp1", 0, 1, 32'h0);
    tick();
    idle();
    expect_val("zr_arr0", 0, 0, 32'h0);
    expect_val("zr_arr1", 0, 1, 32'h0);
    tick();

    // Two ports hit x3: port 1 wins.
    wr(0, 3, 32'hAAAA0000);
    wr(1, 3, 32'h5555FFFF);
    bus.rd_addr[0] = 5'd3;
    bus.rd_addr[1] = 5'd7;
    expect_val("col_byp", 0, 0, 32'h5555FFFF);
    expect_val("col_other", 0, 1, 32'h12345678);
    tick();
    idle();
    expect_val("col_arr", 0, 0, 32'h5555FFFF);
    tick();

    // Scoreboard alloc then write-back of x9.
    alloc(9);
    bus.rd_addr[0] = 5'd9;
    expect_val("sb_pre_pend", 1, 0, 32'h0);
    expect_val("sb_pre_busy", 2, 0, 32'h0);
    tick();
    idle();
    expect_val("sb_pend", 1, 0, 32'h1);
    expect_val("sb_busy", 2, 0, 32'h1);
    tick();
    wr(0, 9, 32'h1);
    expect_val("sb_wr_pend", 1, 0, 32'h0);
    expect_val("sb_wr_data", 0, 0, 32'h1);
    expect_val("sb_wr_busy", 2, 0, 32'h1);
    tick();
    idle();
    expect_val("sb_clr_busy", 2, 0, 32'h0);
    expect_val("sb_clr_pend", 1, 0, 32'h0);
    tick();

    // Alloc and write on a pending x4 in the same cycle: set wins.
    alloc(4);
    bus.rd_addr[0] = 5'd4;
    tick();
    idle();
    alloc(4);
    wr(0, 4, 32'h77);
    expect_val("race_pend", 1, 0, 32'h1);
    expect_val("race_data", 0, 0, 32'h77);
    tick();
    idle();
    expect_val("race_pend_post", 1, 0, 32'h1);
    expect_val("race_data_post", 0, 0, 32'h77);
    expect_val("race_busy", 2, 0, 32'h1);
    tick();

    // Port 1 write-back clears x4 combinationally on read port 1.
    wr(1, 4, 32'h88);
    bus.rd_addr[1] = 5'd4;
    expect_val("p1_pend", 1, 1, 32'h0);
    expect_val("p1_data", 0, 1, 32'h88);
    tick();
    idle();
    expect_val("p1_busy", 2, 0, 32'h0);
    alloc(0);
    tick();
    idle();
    bus.rd_addr[1] = 5'd0;
    expect_val("z_alloc_busy", 2, 0, 32'h0);
    expect_val("z_alloc_pend1", 1, 1, 32'h0);
    tick();

    // Reset mid-operation discards the in-flight write and clears state.
    rst_n = 1'b0;
    wr(0, 10, 32'h0000CAFE);
    tick();
    rst_n = 1'b1;
    idle();
    bus.rd_addr[0] = 5'd10;
    bus.rd_addr[1] = 5'd7;
    expect_val("mr_x10", 0, 0, 32'h0);
    expect_val("mr_x7", 0, 1, 32'h0);
    tick();

    wait_cnt = 0;
    while (sbq.size() > 0 && wait_cnt < 5) begin
      tick();
      wait_cnt++;
    end
    if (sbq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
